// File: rtl/pixel_sink_pkg.sv
// Shared definitions for the pixel result sink: register word indices,
// CTRL bit positions, STATUS bit positions and a STATUS packing helper.
// Imported by pixel_result_sink; no ports.
package pixel_sink_pkg;

  // Register word indices on the CPU register bus
  localparam logic [4:0] REG_DATA      = 5'd0;
  localparam logic [4:0] REG_STATUS    = 5'd1;
  localparam logic [4:0] REG_CTRL      = 5'd2;
  localparam logic [4:0] REG_PIX_POS   = 5'd3;
  localparam logic [4:0] REG_FRAME_CNT = 5'd4;

  // CTRL bits: irq_en is stored, the rest are write-1 pulses that read as 0
  localparam int CTRL_IRQ_EN    = 0;
  localparam int CTRL_CLR_OVF   = 1;
  localparam int CTRL_CLR_FDONE = 2;
  localparam int CTRL_CLR_UDF   = 3;
  localparam int CTRL_FLUSH     = 4;

  // STATUS bit positions
  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FDONE     = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_UDF       = 3;
  localparam int STAT_FULL      = 4;
  localparam int STAT_LEVEL_LSB = 8;

  // Sticky event flags, set by hardware and cleared by software
  typedef struct packed {
    logic udf;
    logic ovf;
    logic fdone;
  } sticky_t;

  function automatic logic [31:0] pack_status(input sticky_t    s,
                                              input logic       empty,
                                              input logic       full,
                                              input logic [7:0] level);
    logic [31:0] w;
    w                          = '0;
    w[STAT_EMPTY]              = empty;
    w[STAT_FDONE]              = s.fdone;
    w[STAT_OVF]                = s.ovf;
    w[STAT_UDF]                = s.udf;
    w[STAT_FULL]               = full;
    w[STAT_LEVEL_LSB +: 8]     = level;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; head is shown combinationally.
// Ports: clk/rstn; push+wdata write; pop advances the head (rdata);
// flush empties it; full/empty/level report occupancy.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  // A pop on a full FIFO frees the slot the same-cycle push lands in
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  assign rdata = mem[rd_ptr];

  // Storage carries no reset: contents are only visible through level
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap on natural overflow
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pixel_result_sink.sv
// Receiving end of the processor's pixel stream: buffers pixels, tracks
// frame position and exposes data/status/counters on a word-indexed bus.
// Ports: clk/rstn; in_valid/in_pixel stream; reg_* register bus with
// combinational reg_rdata; irq registered interrupt (frame done / overflow).
module pixel_result_sink
  import pixel_sink_pkg::*;
#(
  parameter int PIX_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic [PIX_WIDTH-1:0] in_pixel,
  input  logic                 reg_write_en,
  input  logic                 reg_read_en,
  input  logic [4:0]           reg_addr,
  input  logic [31:0]          reg_wdata,
  output logic [31:0]          reg_rdata,
  output logic                 irq
);

  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int POS_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME_PIX - 1);

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LVL_W-1:0]     fifo_level;
  logic [PIX_WIDTH-1:0] fifo_head;

  logic [POS_W-1:0]     pix_pos;
  logic [15:0]          frame_cnt;
  sticky_t              sticky;
  sticky_t              sticky_nxt;
  logic                 irq_en;
  logic                 irq_en_nxt;

  logic data_rd;
  logic ctrl_wr;
  logic flush;
  logic pop_ok;
  logic push_ok;
  logic ovf_set;
  logic udf_set;
  logic fdone_set;
  logic pix_adv;

  // Only CTRL bits [4:0] carry meaning
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata[31:CTRL_FLUSH+1];

  assign data_rd = reg_read_en && (reg_addr == REG_DATA);
  assign ctrl_wr = reg_write_en && (reg_addr == REG_CTRL);
  assign flush   = ctrl_wr && reg_wdata[CTRL_FLUSH];

  // Flush beats any same-cycle push or pop and suppresses overflow
  assign pop_ok  = data_rd && !fifo_empty && !flush;
  assign push_ok = in_valid && !flush && (!fifo_full || pop_ok);
  assign ovf_set = in_valid && !flush && fifo_full && !pop_ok;
  assign udf_set = data_rd && fifo_empty;

  // Dropped (overflowed) pixels still advance the frame position
  assign pix_adv   = in_valid && !flush;
  assign fdone_set = pix_adv && (pix_pos == LAST_POS);

  sync_fifo #(
    .WIDTH (PIX_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_ok),
    .wdata (in_pixel),
    .pop   (pop_ok),
    .rdata (fifo_head),
    .flush (flush),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // A set in the same cycle as a software clear wins: the event is newer
  always_comb begin
    sticky_nxt       = sticky;
    irq_en_nxt       = irq_en;
    if (ctrl_wr) begin
      irq_en_nxt = reg_wdata[CTRL_IRQ_EN];
      if (reg_wdata[CTRL_CLR_OVF])   sticky_nxt.ovf   = 1'b0;
      if (reg_wdata[CTRL_CLR_FDONE]) sticky_nxt.fdone = 1'b0;
      if (reg_wdata[CTRL_CLR_UDF])   sticky_nxt.udf   = 1'b0;
    end
    if (ovf_set)   sticky_nxt.ovf   = 1'b1;
    if (fdone_set) sticky_nxt.fdone = 1'b1;
    if (udf_set)   sticky_nxt.udf   = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sticky    <= '0;
      irq_en    <= 1'b0;
      irq       <= 1'b0;
      pix_pos   <= '0;
      frame_cnt <= '0;
    end else begin
      sticky <= sticky_nxt;
      irq_en <= irq_en_nxt;
      // Built from next-state flags so irq follows its cause by one cycle
      irq    <= irq_en_nxt && (sticky_nxt.fdone || sticky_nxt.ovf);
      if (flush) begin
        pix_pos <= '0;
      end else if (fdone_set) begin
        pix_pos   <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (pix_adv) begin
        pix_pos <= pix_pos + POS_W'(1);
      end
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      REG_DATA:      reg_rdata = fifo_empty ? '0 : 32'(fifo_head);
      REG_STATUS:    reg_rdata = pack_status(sticky, fifo_empty, fifo_full,
                                             8'(fifo_level));
      REG_CTRL:      reg_rdata = {31'd0, irq_en};
      REG_PIX_POS:   reg_rdata = 32'(pix_pos);
      REG_FRAME_CNT: reg_rdata = {16'd0, frame_cnt};
      default:       reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pixel_result_sink.sv
// Directed bench for pixel_result_sink with hand-computed expectations.
// Ports: none (top-level bench); drives the DUT and prints one summary line.
module tb_pixel_result_sink;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [31:0] in_pixel;
  logic        reg_write_en;
  logic        reg_read_en;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        irq;

  int n_cmp;
  int n_err;

  pixel_result_sink #(
    .PIX_WIDTH  (32),
    .FIFO_DEPTH (16),
    .IMG_WIDTH  (32),
    .IMG_HEIGHT (32)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_pixel     (in_pixel),
    .reg_write_en (reg_write_en),
    .reg_read_en  (reg_read_en),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p);
    in_valid = 1'b1;
    in_pixel = p;
    step();
    in_valid = 1'b0;
  endtask

  task automatic reg_rd(input logic [4:0] a, output logic [31:0] d);
    reg_read_en = 1'b1;
    reg_addr    = a;
    #1;
    d = reg_rdata;
    step();
    reg_read_en = 1'b0;
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [31:0] w);
    reg_write_en = 1'b1;
    reg_addr     = a;
    reg_wdata    = w;
    step();
    reg_write_en = 1'b0;
  endtask

  // Read of a side-effect-free register, combinational only
  task automatic peek(input logic [4:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  logic [31:0] d;
  logic [31:0] exp_q [$];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    reg_write_en = 1'b0;
    reg_read_en = 1'b0;
    reg_addr = '0;
    reg_wdata = '0;
    #12;

    // Reset state
    peek(5'd1, d); check("rst_status", d, 32'h1);
    peek(5'd3, d); check("rst_pix_pos", d, 32'h0);
    peek(5'd4, d); check("rst_frame", d, 32'h0);
    peek(5'd2, d); check("rst_ctrl", d, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    rstn = 1'b1;
    step();

    // Basic push then drain
    push(32'h11); push(32'h22); push(32'h33);
    peek(5'd1, d); check("lvl3", d, 32'h0300);
    reg_rd(5'd0, d); check("rd_11", d, 32'h11);
    peek(5'd1, d); check("lvl2", d, 32'h0200);
    reg_rd(5'd0, d); check("rd_22", d, 32'h22);
    reg_rd(5'd0, d); check("rd_33", d, 32'h33);
    peek(5'd1, d); check("drained", d, 32'h1);

    // Overflow with interrupt enabled
    reg_wr(5'd2, 32'h1);
    peek(5'd2, d); check("ctrl_irq_en", d, 32'h1);
    for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
    peek(5'd1, d); check("full16", d, 32'h1010);
    check("irq_pre_ovf", {31'd0, irq}, 32'h0);
    push(32'h1FF);
    check("irq_ovf", {31'd0, irq}, 32'h1);
    peek(5'd1, d); check("ovf_status", d, 32'h1014);
    reg_rd(5'd0, d); check("first_after_ovf", d, 32'h100);
    push(32'h200);
    reg_wr(5'd2, 32'h3);
    check("irq_ovf_clr", {31'd0, irq}, 32'h0);
    peek(5'd1, d); check("ovf_cleared", d, 32'h1010);

    // Push and pop together while full
    in_valid = 1'b1; in_pixel = 32'hAA;
    reg_rd(5'd0, d);
    in_valid = 1'b0;
    check("simul_rd", d, 32'h101);
    peek(5'd1, d); check("simul_status", d, 32'h1010);
    for (int i = 2; i < 16; i++) exp_q.push_back(32'h100 + 32'(i));
    exp_q.push_back(32'h200);
    exp_q.push_back(32'hAA);
    for (int i = 0; i < 16; i++) begin
      reg_rd(5'd0, d);
      check($sformatf("drain_%0d", i), d, exp_q[i]);
    end
    peek(5'd1, d); check("drain_empty", d, 32'h1);
    peek(5'd3, d); check("pix_pos22", d, 32'd22);

    // Flush to restart the frame, then stream a full frame while draining
    reg_wr(5'd2, 32'h11);
    peek(5'd3, d); check("flush_pos", d, 32'h0);
    for (int i = 0; i < 1024; i++) begin
      in_valid = 1'b1; in_pixel = 32'(i);
      reg_read_en = 1'b1; reg_addr = 5'd0;
      #1;
      check("stream_rd", reg_rdata, (i == 0) ? 32'h0 : 32'(i - 1));
      if (i == 1023) check("irq_pre_fdone", {31'd0, irq}, 32'h0);
      step();
    end
    in_valid = 1'b0; reg_read_en = 1'b0;
    check("irq_fdone", {31'd0, irq}, 32'h1);
    peek(5'd1, d); check("fdone_status", d, 32'h010A);
    peek(5'd4, d); check("frame1", d, 32'h1);
    peek(5'd3, d); check("pos_wrap", d, 32'h0);
    reg_rd(5'd0, d); check("last_pix", d, 32'h3FF);
    reg_wr(5'd2, 32'h5);
    check("irq_fdone_clr", {31'd0, irq}, 32'h0);
    peek(5'd1, d); check("fdone_cleared", d, 32'h9);

    // Underflow
    reg_wr(5'd2, 32'h9);
    peek(5'd1, d); check("udf_cleared0", d, 32'h1);
    reg_rd(5'd0, d); check("udf_rdata", d, 32'h0);
    peek(5'd1, d); check("udf_set", d, 32'h9);
    reg_wr(5'd2, 32'h9);
    peek(5'd1, d); check("udf_cleared", d, 32'h1);
    check("irq_udf", {31'd0, irq}, 32'h0);
    peek(5'd7, d); check("unmapped", d, 32'h0);

    // Flush coincident with a push
    for (int i = 0; i < 5; i++) push(32'h50 + 32'(i));
    peek(5'd1, d); check("lvl5", d, 32'h0500);
    peek(5'd3, d); check("pos5", d, 32'd5);
    in_valid = 1'b1; in_pixel = 32'hEE;
    reg_wr(5'd2, 32'h11);
    in_valid = 1'b0;
    peek(5'd1, d); check("flush_status", d, 32'h1);
    peek(5'd3, d); check("flush_pos2", d, 32'h0);
    peek(5'd4, d); check("flush_frame", d, 32'h1);

    // Asynchronous reset mid-stream
    in_valid = 1'b1; in_pixel = 32'h77;
    step(); step();
    #2;
    rstn = 1'b0;
    #1;
    in_valid = 1'b0;
    peek(5'd1, d); check("arst_status", d, 32'h1);
    peek(5'd3, d); check("arst_pos", d, 32'h0);
    peek(5'd4, d); check("arst_frame", d, 32'h0);
    peek(5'd2, d); check("arst_ctrl", d, 32'h0);
    peek(5'd0, d); check("arst_data", d, 32'h0);
    check("arst_irq", {31'd0, irq}, 32'h0);
    step();
    rstn = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
